// File: rtl/dac_sample_arbiter_if.sv
// ============================================================================
// Module   : dac_sample_arbiter_if
// Brief    : Source/DAC bundle for dac_sample_arbiter. Statistics ports exist
//            only when DAC_SAMPLE_ARBITER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dac_sample_arbiter_if #(
    parameter int NUM_SRC    = 2,
    parameter int CODE_WIDTH = 10
);
    localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*CODE_WIDTH-1:0] src_code;
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_enable;
    logic [NUM_SRC-1:0]            src_ready;
    logic                          next_sample;
    logic [CODE_WIDTH-1:0]         code;
    logic [AW-1:0]                 active_src;
    logic                          underflow;
    logic                          starved;
`ifdef DAC_SAMPLE_ARBITER_STATS_EN
    logic [15:0]                   underflow_count;
    logic [NUM_SRC*16-1:0]         grant_count;

    modport master (
        output src_code, src_valid, src_enable, next_sample,
        input  src_ready, code, active_src, underflow, starved,
        input  underflow_count, grant_count
    );
    modport slave (
        input  src_code, src_valid, src_enable, next_sample,
        output src_ready, code, active_src, underflow, starved,
        output underflow_count, grant_count
    );
`else
    modport master (
        output src_code, src_valid, src_enable, next_sample,
        input  src_ready, code, active_src, underflow, starved
    );
    modport slave (
        input  src_code, src_valid, src_enable, next_sample,
        output src_ready, code, active_src, underflow, starved
    );
`endif
endinterface

`default_nettype wire

// File: rtl/dac_sample_arbiter.sv
// ============================================================================
// Module   : dac_sample_arbiter
// Brief    : Round-robin sharing of one PWM DAC between NUM_SRC producers with
//            hold-then-silence starvation handling. Optional statistics
//            counters enabled by DAC_SAMPLE_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_sample_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int CODE_WIDTH = 10,
    parameter int HOLD_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dac_sample_arbiter_if.slave bus
);
    localparam int             AW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [AW:0]    c_num  = (AW+1)'(NUM_SRC);
    localparam logic [AW-1:0]  c_last = AW'(NUM_SRC - 1);
    localparam logic [7:0]     c_hold = 8'(HOLD_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STARVE = 2'd2
    } state_t;

    state_t                r_state;
    logic [CODE_WIDTH-1:0] r_code;
    logic [AW-1:0]         r_active;
    logic [AW-1:0]         r_ptr;
    logic [7:0]            r_miss;
    logic                  r_underflow;
    logic                  r_starved;

    logic [NUM_SRC-1:0]    w_elig;
    logic [NUM_SRC-1:0]    w_rot;
    logic [NUM_SRC-1:0]    w_onehot;
    logic                  w_found;
    logic                  w_grant;
    logic                  w_miss_evt;
    logic [AW-1:0]         w_off;
    logic [AW-1:0]         w_gidx;
    logic [AW:0]           w_sum;
    logic [CODE_WIDTH-1:0] w_sample;

    // Rotate eligibility so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        w_elig  = bus.src_valid & bus.src_enable;
        w_rot   = NUM_SRC'({w_elig, w_elig} >> r_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = AW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_num) begin
            w_sum = w_sum - c_num;
        end
        w_gidx     = w_sum[AW-1:0];
        w_grant    = bus.next_sample & w_found & ~rst;
        w_miss_evt = bus.next_sample & ~w_found & ~rst & (r_state != ST_IDLE);
        w_onehot   = w_grant ? (NUM_SRC'(1) << w_gidx) : '0;
        w_sample   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_gidx == AW'(i)) begin
                w_sample = bus.src_code[i*CODE_WIDTH +: CODE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_code      <= '0;
            r_active    <= '0;
            r_ptr       <= '0;
            r_miss      <= '0;
            r_underflow <= 1'b0;
            r_starved   <= 1'b0;
        end else begin
            r_underflow <= w_miss_evt;
            if (w_grant) begin
                r_state   <= ST_RUN;
                r_code    <= w_sample;
                r_active  <= w_gidx;
                r_ptr     <= (w_gidx == c_last) ? '0 : w_gidx + 1'b1;
                r_miss    <= '0;
                r_starved <= 1'b0;
            end else if (w_miss_evt && r_state == ST_RUN) begin
                // Hold the last code until the miss budget is spent, then go silent.
                r_miss <= r_miss + 8'd1;
                if (r_miss + 8'd1 >= c_hold) begin
                    r_state   <= ST_STARVE;
                    r_code    <= '0;
                    r_starved <= 1'b1;
                end
            end
        end
    end

    assign bus.src_ready  = w_onehot;
    assign bus.code       = r_code;
    assign bus.active_src = r_active;
    assign bus.underflow  = r_underflow;
    assign bus.starved    = r_starved;

`ifdef DAC_SAMPLE_ARBITER_STATS_EN
    logic [15:0] r_underflow_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow_count <= '0;
        end else if (w_miss_evt && r_underflow_count != 16'hFFFF) begin
            r_underflow_count <= r_underflow_count + 16'd1;
        end
    end

    assign bus.underflow_count = r_underflow_count;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_grant_cnt
        logic [15:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_onehot[g] && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign bus.grant_count[g*16 +: 16] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: doc/dac_sample_arbiter.md
Name: dac_sample_arbiter

Overview:
- Shares the single PWM DAC between NUM_SRC sample producers (tone generator, sample FIFO, etc.).
- On each DAC window-boundary strobe, picks one enabled, valid source round-robin, pops one sample and drives the DAC code input for the whole next window.
- Handles starvation: holds the last code, then forces silence after HOLD_LIMIT consecutive empty windows.

Parameters:
- NUM_SRC, 2, number of requesters (2..8).
- CODE_WIDTH, 10, sample/DAC code width in bits.
- HOLD_LIMIT, 4, consecutive underflow windows tolerated before output is forced to 0 (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- src_code  in  NUM_SRC*CODE_WIDTH  packed samples; source i occupies bits [i*CODE_WIDTH +: CODE_WIDTH]
- src_valid  in  NUM_SRC  source i has a sample available
- src_enable  in  NUM_SRC  configuration mask; disabled sources are never granted
- src_ready  out  NUM_SRC  one-hot pop strobe to the granted source
- next_sample  in  1  single-cycle DAC strobe, asserted in the last cycle of a PWM window
- code  out  CODE_WIDTH  registered code to the DAC
- active_src  out  $clog2(NUM_SRC) (min 1)  index of the last granted source
- underflow  out  1  registered one-cycle pulse; a window boundary had no eligible source
- starved  out  1  high while in STARVE

Behaviour:
- Reset values: code=0, src_ready=0, active_src=0, underflow=0, starved=0, state=IDLE, round-robin pointer=0, miss counter=0.
- Eligible source: src_valid[i] & src_enable[i].
- Grant:
  - Combinational, only in a cycle with next_sample=1.
  - The first eligible index searching pointer, pointer+1, ... modulo NUM_SRC.
- src_ready:
  - Combinational one-hot, high only in the next_sample cycle, only for the granted index.
  - Sources pop on src_ready & src_valid in that cycle.
  - src_ready=0 whenever next_sample=0 or no source is eligible.
- On the clock edge ending a granted next_sample cycle:
  - code <= granted sample; active_src <= grant; pointer <= (grant+1) mod NUM_SRC; miss counter <= 0.
  - Latency: the sample appears on code the cycle after the pop, i.e. the first cycle of the new window. code stays stable for the full window.
- States:
  - IDLE: code=0. Grant -> RUN. No grant -> stay in IDLE, with no underflow pulse.
  - RUN:
    - Grant -> RUN.
    - No grant: underflow pulses for 1 cycle; code holds its previous value; miss counter increments. When miss counter reaches HOLD_LIMIT -> STARVE, with code <= 0 on the same edge.
  - STARVE: starved=1, code=0. No grant -> underflow pulses each boundary; miss counter saturates. Grant -> RUN with the new code.
- src_enable changes take effect at the next next_sample. Disabling the granted source mid-window does not alter code.
- src_valid or src_enable changes between strobes have no effect.
- Pointer wrap: after granting NUM_SRC-1 the pointer returns to 0.
- rst asserted mid-window or in a next_sample cycle:
  - rst wins; no src_ready is asserted in that cycle.
  - All outputs return to reset values next cycle.
- next_sample high for consecutive cycles: each cycle is treated as an independent boundary. This is not expected from the DAC.

Optional Feature:
- Macro: DAC_SAMPLE_ARBITER_STATS_EN.
- With the macro:
  - Adds output underflow_count, 16 bits. It increments on each underflow pulse, saturates at 0xFFFF and clears on rst.
  - Adds output grant_count, NUM_SRC*16 bits. Each 16-bit field increments per grant to that source, saturating.
- Without the macro: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, no sources valid, 3 strobes -> code=0, state stays IDLE, underflow never pulses, src_ready=0.
- Src0=0x100 and src1=0x200 both always valid and enabled, 4 strobes -> grants 0,1,0,1; code=0x100,0x200,0x100,0x200, each updated the cycle after its strobe; exactly one src_ready per strobe.
- src_enable=2'b10 with both valid -> only src1 granted every strobe; src_ready[0] never asserts.
- After code=0x155, drop all valids for 5 strobes with HOLD_LIMIT=4 -> underflow pulses 5 times; code=0x155 for the first 3 windows, then 0 with starved=1 from the 4th boundary; valid src0=0x0AA at the next strobe -> RUN, code=0x0AA, starved=0.
- Assert rst in a next_sample cycle with src1 valid -> no src_ready that cycle; code=0, active_src=0 next cycle; the next grant starts from index 0.
- With DAC_SAMPLE_ARBITER_STATS_EN: 3 underflows and 2 src0 grants -> underflow_count=3, grant_count[0]=2; rst clears both counters to 0.
